alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance (ops: OR/AND/ADD) between N_REQ requesters, e.g. the
//  execute stage and an address-generation unit of the RISC datapath.
//  Per-requester valid/ready request ports feed one registered response bus tagged with
//  the requester id. Round-robin grant; one operation in flight at a time.
// PARAMETERS
//  N_REQ   2   number of requesters (2..4)
//  ID_W    1   width of rsp_id; must equal clog2(N_REQ) (1 when N_REQ=2)
//  DATA_W  32  operand/result width; matches the ALU
// PORTS
//  clk          in   1             rising-edge clock
//  reset        in   1             synchronous, active-high reset
//  req_valid    in   N_REQ         requester i has an operation pending
//  req_ready    out  N_REQ         one-hot grant; handshake completes when valid&ready
//  req_a        in   N_REQ*DATA_W  operand A, requester i at slice i
//  req_b        in   N_REQ*DATA_W  operand B, requester i at slice i
//  req_op       in   N_REQ*5       5-bit ALU opcode, requester i at slice i
//  rsp_valid    out  1             result held on rsp_data
//  rsp_ready    in   1             consumer accepts result
//  rsp_data     out  DATA_W        ALU result
//  rsp_id       out  ID_W          index of the requester that owns rsp_data
//  rsp_illegal  out  1             opcode was not 0/1/2 (ALU executed its default, AND)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   rsp_illegal=0, operand registers=0. Reset asserted in any state aborts the operation;
//   the in-flight result is discarded, not delivered.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready = one-hot of the winner among req_valid, searching upward from rr_ptr
//    with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...). req_ready is combinational from
//    req_valid/rr_ptr, but only in IDLE. If no req_valid, req_ready=0 and stay in IDLE.
//    On handshake: latch A/B/op/id into operand registers; rr_ptr <= (winner+1) mod N_REQ;
//    go to EXEC.
//   EXEC: ALU is driven from the operand registers. Its output is registered into rsp_data;
//    rsp_id and rsp_illegal are set; rsp_valid <= 1; go to RESP. req_ready=0.
//   RESP: rsp_valid=1; rsp_data/rsp_id/rsp_illegal stay stable until rsp_ready=1. On
//    rsp_ready: rsp_valid <= 0, go to IDLE. req_ready=0.
//  Latency: handshake in cycle t -> rsp_valid high from cycle t+2. Peak throughput is one
//   op per 3 cycles with rsp_ready tied high.
//  Arithmetic: ADD is modulo 2^DATA_W; carry-out dropped, no overflow flag. Opcode 0=OR,
//   1=AND, 2=ADD; 3..31 give the AND result and rsp_illegal=1.
//  Fairness: a requester holding req_valid is granted within N_REQ grants. A requester
//   may drop req_valid without a handshake; no grant is then issued to it.
//  rr_ptr changes only on a completed handshake.
//  Operand registers do not change outside the IDLE handshake, so request-bus changes
//   while in EXEC/RESP have no effect.
// STRUCTURE
//  Shared package alu_pkg: ALU_OR=5'd0, ALU_AND=5'd1, ALU_ADD=5'd2, DATA_W, and the
//   arb_state_t enum {IDLE, EXEC, RESP}.
//  Sub-module rr_pick: combinational round-robin priority picker (req vector + pointer
//   -> one-hot grant + index).
//  The FSM, operand registers and one ALU instance live in alu_arbiter.
// TESTING
//  1 Reset, then req0: A=5, B=7, op=2 -> req_ready=01 in same cycle; 2 cycles later
//    rsp_valid=1, rsp_data=12, rsp_id=0, rsp_illegal=0.
//  2 Both requesters valid continuously; rsp_ready=1; req0 op=0 A=F0 B=0F, req1 op=1
//    A=FF B=3C -> grants alternate 0,1,0,1; results FF and 3C, tagged 0 and 1.
//  3 ADD A=FFFFFFFF, B=1 -> rsp_data=0 (wrap). ADD A=7FFFFFFF, B=1 -> 80000000.
//  4 op=7, A=0C, B=0A -> rsp_data=08, rsp_illegal=1.
//  5 Hold rsp_ready=0 for 5 cycles in RESP while req1 stays valid -> rsp outputs stable,
//    req_ready=00. After rsp_ready pulses: IDLE, then req1 granted next cycle.
//  6 Assert reset during EXEC, then during RESP -> next cycle all outputs at reset
//    values, rsp_valid never seen for the aborted op; rr_ptr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, datapath width and FSM state type for the ALU arbiter.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] ALU_OR  = 5'd0;
  localparam logic [4:0] ALU_AND = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one OR/AND/ADD ALU between N_REQ requesters,
// one operation in flight, registered response tagged with the requester id.
module alu_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*5-1:0]      req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_illegal
);

  import alu_pkg::*;

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [4:0]        op_code_q, op_code_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_illegal_q, rsp_illegal_d;

  logic [N_REQ-1:0]  win_grant;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic [DATA_W-1:0] alu_res;
  logic              alu_illegal;

  rr_pick #(
    .N_REQ (int'(N_REQ)),
    .ID_W  (int'(ID_W))
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Single ALU, fed only from the operand registers; unknown opcodes fall back to AND.
  always_comb begin
    alu_res     = op_a_q & op_b_q;
    alu_illegal = 1'b0;
    case (op_code_q)
      ALU_OR:  alu_res = op_a_q | op_b_q;
      ALU_AND: alu_res = op_a_q & op_b_q;
      ALU_ADD: alu_res = op_a_q + op_b_q;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_code_d     = op_code_q;
    op_id_d       = op_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_illegal_d = rsp_illegal_q;
    req_ready     = '0;

    case (state_q)
      IDLE: begin
        // No grant is offered while reset is held, so no requester sees a phantom handshake.
        if (!reset && win_any) begin
          req_ready = win_grant;
          op_a_d    = req_a[win_idx*DATA_W +: DATA_W];
          op_b_d    = req_b[win_idx*DATA_W +: DATA_W];
          op_code_d = req_op[win_idx*5 +: 5];
          op_id_d   = win_idx;
          rr_ptr_d  = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d    = alu_res;
        rsp_id_d      = op_id_q;
        rsp_illegal_d = alu_illegal;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_code_q     <= '0;
      op_id_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_code_q     <= op_code_d;
      op_id_q       <= op_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: fixed vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*5-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [0:0]     rsp_id;
  logic           rsp_illegal;

  alu_arbiter #(.N_REQ(N), .ID_W(1), .DATA_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input int op);
    case (op)
      0:       return a | b;
      1:       return a & b;
      2:       return a + b;
      default: return a & b;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_op[r*5 +: 5] = op;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t tbl[9];

  int          m_phase, m_ptr, m_id, w;
  logic [31:0] m_res;
  logic        m_ill;
  logic [31:0] ra[N];
  logic [31:0] rb[N];
  int          rop[N];
  logic [N-1:0] rv;
  logic [N-1:0] exp_rdy;

  initial begin
    tbl[0] = '{32'd5,        32'd7,        5'd2,  32'd12,        1'b0};
    tbl[1] = '{32'hF0,       32'h0F,       5'd0,  32'hFF,        1'b0};
    tbl[2] = '{32'hFF,       32'h3C,       5'd1,  32'h3C,        1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'd1,        5'd2,  32'h0,         1'b0};
    tbl[4] = '{32'h7FFFFFFF, 32'd1,        5'd2,  32'h80000000,  1'b0};
    tbl[5] = '{32'h0C,       32'h0A,       5'd7,  32'h08,        1'b1};
    tbl[6] = '{32'h0C,       32'h0A,       5'd3,  32'h08,        1'b1};
    tbl[7] = '{32'hF0F0_1234, 32'h0FF0_4321, 5'd31, 32'h00F0_0220, 1'b1};
    tbl[8] = '{32'hAAAA0000, 32'h5555FFFF, 5'd0,  32'hFFFFFFFF,  1'b0};

    req_a = '0; req_b = '0; req_op = '0;
    req_valid = '0; rsp_ready = 1'b1; reset = 1'b1;
    cyc();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_illegal", rsp_illegal, 0);
    do_reset();

    // Vector table: single requester, handshake then response two cycles later.
    for (int k = 0; k < 9; k++) begin
      int r;
      r = k % 2;
      set_req(r, tbl[k].a, tbl[k].b, tbl[k].op);
      req_valid = '0;
      req_valid[r] = 1'b1;
      #1;
      chk("tbl_grant", req_ready, 64'(1) << r);
      chk("tbl_early_valid", rsp_valid, 0);
      cyc();
      req_valid = '0;
      chk("tbl_exec_ready", req_ready, 0);
      chk("tbl_exec_valid", rsp_valid, 0);
      cyc();
      chk("tbl_rsp_valid", rsp_valid, 1);
      chk("tbl_rsp_data", rsp_data, tbl[k].exp);
      chk("tbl_rsp_id", rsp_id, r);
      chk("tbl_rsp_illegal", rsp_illegal, tbl[k].ill);
      cyc();
      chk("tbl_back_idle", rsp_valid, 0);
    end

    // Both requesters busy: grants alternate starting at 0.
    do_reset();
    set_req(0, 32'hF0, 32'h0F, 5'd0);
    set_req(1, 32'hFF, 32'h3C, 5'd1);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % 2;
      #1;
      chk("alt_grant", req_ready, 64'(1) << e);
      cyc();
      cyc();
      chk("alt_rsp_valid", rsp_valid, 1);
      chk("alt_rsp_data", rsp_data, (e == 0) ? 32'hFF : 32'h3C);
      chk("alt_rsp_id", rsp_id, e);
      cyc();
    end
    req_valid = '0;

    // Response backpressure while req1 waits.
    do_reset();
    set_req(0, 32'd1, 32'd2, 5'd2);
    set_req(1, 32'd3, 32'd4, 5'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant0", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10;
    set_req(0, 32'hDEAD, 32'hBEEF, 5'd1);
    cyc();
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 3);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", req_ready, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    #1;
    chk("bp_released", rsp_valid, 0);
    chk("bp_grant1", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    cyc();
    chk("bp_rsp1_data", rsp_data, 7);
    chk("bp_rsp1_id", rsp_id, 1);
    cyc();

    // Reset during EXEC, then during RESP.
    do_reset();
    set_req(0, 32'd5, 32'd6, 5'd2);
    set_req(1, 32'd9, 32'd9, 5'd2);
    req_valid = 2'b01;
    #1;
    chk("rx_grant", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    reset = 1'b1;
    cyc();
    chk("rx_valid", rsp_valid, 0);
    chk("rx_data", rsp_data, 0);
    chk("rx_id", rsp_id, 0);
    chk("rx_illegal", rsp_illegal, 0);
    chk("rx_ready", req_ready, 0);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("rx_no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1;
    chk("rx_ptr_zero", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    cyc();
    chk("rr_pre_valid", rsp_valid, 1);
    reset = 1'b1;
    cyc();
    chk("rr_valid", rsp_valid, 0);
    chk("rr_data", rsp_data, 0);
    chk("rr_id", rsp_id, 0);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("rr_no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1;
    chk("rr_ptr_zero", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Randomized traffic against the reference model.
    do_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_res = '0; m_ill = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rv = N'($urandom_range(0, 3));
      for (int r = 0; r < N; r++) begin
        ra[r]  = $urandom;
        rb[r]  = $urandom;
        rop[r] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 31))
                                             : int'($urandom_range(0, 2));
        set_req(r, ra[r], rb[r], 5'(rop[r]));
      end
      req_valid = rv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && rv[j]) w = j;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_valid", rsp_valid, (m_phase == 2));
      if (m_phase == 2) begin
        chk("rnd_data", rsp_data, m_res);
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_illegal", rsp_illegal, m_ill);
      end
      case (m_phase)
        0: if (w >= 0) begin
             m_res   = ref_alu(ra[w], rb[w], rop[w]);
             m_ill   = (rop[w] > 2);
             m_id    = w;
             m_ptr   = (w + 1) % N;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
